db_settings_initiator: RTL and testbench

DB_SETTINGS_INITIATOR -- requirements
Module: db_settings_initiator

---
 rtl/db_settings_initiator.sv | 107 ++++++++++
 tb/tb_db_settings_initiator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/db_settings_initiator.sv
// Settings-bus initiator: turns AXI-Stream commands into settings writes or
// timed readbacks, and returns one AXI-Stream response per command.
module db_settings_initiator #(
  parameter int RB_TIMEOUT = 64,
  parameter int ACK_WRITES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] cmd_tdata,
  input  logic        cmd_tuser,
  input  logic        cmd_tvalid,
  output logic        cmd_tready,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic [7:0]  rb_addr,
  input  logic        rb_stb,
  input  logic [63:0] rb_data,
  output logic [63:0] resp_tdata,
  output logic [9:0]  resp_tuser,
  output logic        resp_tvalid,
  input  logic        resp_tready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WRITE, RB_WAIT, RESP} state_t;

  localparam logic [15:0] LAST_COUNT = 16'(RB_TIMEOUT - 1);

  state_t      state;
  logic [15:0] count;
  logic        accept;

  // Gating with reset keeps the handshake closed while reset is held.
  assign cmd_tready = (state == IDLE) && !reset;
  assign busy       = (state != IDLE);
  assign accept     = cmd_tvalid && cmd_tready;

  // NOTE: every register here, including the data holding registers, is reset so
  // an aborted command leaves nothing visible behind; all updates are non-blocking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      set_stb     <= 1'b0;
      set_addr    <= '0;
      set_data    <= '0;
      rb_addr     <= '0;
      resp_tdata  <= '0;
      resp_tuser  <= '0;
      resp_tvalid <= 1'b0;
    end else begin
      set_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            // Tag and command kind ride in resp_tuser until the response leaves.
            resp_tuser <= {1'b0, cmd_tuser, cmd_tdata[47:40]};
            if (cmd_tuser) begin
              rb_addr <= cmd_tdata[39:32];
              count   <= '0;
              state   <= RB_WAIT;
            end else begin
              set_stb  <= 1'b1;
              set_addr <= cmd_tdata[39:32];
              set_data <= cmd_tdata[31:0];
              state    <= WRITE;
            end
          end
        end
        WRITE: begin
          if (ACK_WRITES != 0) begin
            resp_tdata  <= '0;
            resp_tvalid <= 1'b1;
            state       <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RB_WAIT: begin
          // A strobe on the last window cycle still wins over the timeout.
          if (rb_stb) begin
            resp_tdata    <= rb_data;
            resp_tuser[9] <= 1'b0;
            resp_tvalid   <= 1'b1;
            state         <= RESP;
          end else if (count == LAST_COUNT) begin
            resp_tdata    <= '0;
            resp_tuser[9] <= 1'b1;
            resp_tvalid   <= 1'b1;
            state         <= RESP;
          end else begin
            count <= count + 16'd1;
          end
        end
        RESP: begin
          if (resp_tready) begin
            resp_tvalid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_db_settings_initiator.sv
// Directed bench for db_settings_initiator: default instance, a short-timeout
// instance and a silent-write instance share one stimulus stream.
module tb_db_settings_initiator;

  logic        clk;
  logic        reset;
  logic [47:0] cmd_tdata;
  logic        cmd_tuser;
  logic        cmd_tvalid;
  logic        rb_stb;
  logic [63:0] rb_data;
  logic        resp_tready;

  logic        a_cmd_tready, a_set_stb, a_resp_tvalid, a_busy;
  logic [7:0]  a_set_addr, a_rb_addr;
  logic [31:0] a_set_data;
  logic [63:0] a_resp_tdata;
  logic [9:0]  a_resp_tuser;

  logic        t_cmd_tready, t_set_stb, t_resp_tvalid, t_busy;
  logic [7:0]  t_set_addr, t_rb_addr;
  logic [31:0] t_set_data;
  logic [63:0] t_resp_tdata;
  logic [9:0]  t_resp_tuser;

  logic        s_cmd_tready, s_set_stb, s_resp_tvalid, s_busy;
  logic [7:0]  s_set_addr, s_rb_addr;
  logic [31:0] s_set_data;
  logic [63:0] s_resp_tdata;
  logic [9:0]  s_resp_tuser;

  int errors = 0;
  int checks = 0;

  db_settings_initiator dut_a (
    .clk(clk), .reset(reset), .cmd_tdata(cmd_tdata), .cmd_tuser(cmd_tuser),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(a_cmd_tready), .set_stb(a_set_stb),
    .set_addr(a_set_addr), .set_data(a_set_data), .rb_addr(a_rb_addr),
    .rb_stb(rb_stb), .rb_data(rb_data), .resp_tdata(a_resp_tdata),
    .resp_tuser(a_resp_tuser), .resp_tvalid(a_resp_tvalid),
    .resp_tready(resp_tready), .busy(a_busy)
  );

  db_settings_initiator #(.RB_TIMEOUT(4)) dut_t (
    .clk(clk), .reset(reset), .cmd_tdata(cmd_tdata), .cmd_tuser(cmd_tuser),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(t_cmd_tready), .set_stb(t_set_stb),
    .set_addr(t_set_addr), .set_data(t_set_data), .rb_addr(t_rb_addr),
    .rb_stb(rb_stb), .rb_data(rb_data), .resp_tdata(t_resp_tdata),
    .resp_tuser(t_resp_tuser), .resp_tvalid(t_resp_tvalid),
    .resp_tready(resp_tready), .busy(t_busy)
  );

  db_settings_initiator #(.ACK_WRITES(0)) dut_s (
    .clk(clk), .reset(reset), .cmd_tdata(cmd_tdata), .cmd_tuser(cmd_tuser),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(s_cmd_tready), .set_stb(s_set_stb),
    .set_addr(s_set_addr), .set_data(s_set_data), .rb_addr(s_rb_addr),
    .rb_stb(rb_stb), .rb_data(rb_data), .resp_tdata(s_resp_tdata),
    .resp_tuser(s_resp_tuser), .resp_tvalid(s_resp_tvalid),
    .resp_tready(resp_tready), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] tag, input logic [7:0] addr,
                      input logic [31:0] data, input logic is_read);
    cmd_tdata  = {tag, addr, data};
    cmd_tuser  = is_read;
    cmd_tvalid = 1'b1;
    check("cmd_tready_before_accept", 64'(a_cmd_tready), 64'd1);
    tick();
    cmd_tvalid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    cmd_tdata   = '0;
    cmd_tuser   = 1'b0;
    cmd_tvalid  = 1'b0;
    rb_stb      = 1'b0;
    rb_data     = '0;
    resp_tready = 1'b1;

    // Reset state
    #2;
    check("rst_cmd_tready", 64'(a_cmd_tready), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_set_stb", 64'(a_set_stb), 64'd0);
    check("rst_resp_tvalid", 64'(a_resp_tvalid), 64'd0);
    check("rst_resp_tuser", 64'(a_resp_tuser), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_cmd_tready", 64'(a_cmd_tready), 64'd1);
    tick();

    // Acknowledged write
    send(8'h11, 8'hA0, 32'hDEADBEEF, 1'b0);
    check("wr_set_stb_n1", 64'(a_set_stb), 64'd1);
    check("wr_set_addr", 64'(a_set_addr), 64'hA0);
    check("wr_set_data", 64'(a_set_data), 64'hDEADBEEF);
    check("wr_busy", 64'(a_busy), 64'd1);
    check("wr_cmd_tready_low", 64'(a_cmd_tready), 64'd0);
    check("wr_resp_not_yet", 64'(a_resp_tvalid), 64'd0);
    check("silent_set_stb", 64'(s_set_stb), 64'd1);
    tick();
    check("wr_set_stb_one_cycle", 64'(a_set_stb), 64'd0);
    check("wr_resp_tvalid_n2", 64'(a_resp_tvalid), 64'd1);
    check("wr_resp_tdata", a_resp_tdata, 64'd0);
    check("wr_resp_tuser", 64'(a_resp_tuser), 64'h011);
    check("silent_no_resp", 64'(s_resp_tvalid), 64'd0);
    check("silent_back_idle", 64'(s_cmd_tready), 64'd1);
    tick();
    check("wr_done_tvalid", 64'(a_resp_tvalid), 64'd0);
    check("wr_done_idle", 64'(a_cmd_tready), 64'd1);

    // Read with backpressure; the 4-cycle instance times out meanwhile
    resp_tready = 1'b0;
    send(8'h22, 8'h10, 32'h0, 1'b1);
    check("rd_rb_addr", 64'(a_rb_addr), 64'h10);
    check("rd_no_set_stb", 64'(a_set_stb), 64'd0);
    check("rd_set_addr_held", 64'(a_set_addr), 64'hA0);
    check("rd_busy", 64'(a_busy), 64'd1);
    tick();
    tick();
    tick();
    check("to_not_early", 64'(t_resp_tvalid), 64'd0);
    tick();
    check("to_resp_tvalid", 64'(t_resp_tvalid), 64'd1);
    check("to_resp_tdata", t_resp_tdata, 64'd0);
    check("to_resp_tuser", 64'(t_resp_tuser), 64'h322);
    check("rd_still_waiting", 64'(a_resp_tvalid), 64'd0);
    rb_stb  = 1'b1;
    rb_data = 64'h0123456789ABCDEF;
    tick();
    rb_stb  = 1'b0;
    rb_data = '0;
    check("to_stale_ignored", t_resp_tdata, 64'd0);
    check("to_tuser_stable", 64'(t_resp_tuser), 64'h322);
    for (int i = 0; i < 10; i++) begin
      check("bp_tvalid", 64'(a_resp_tvalid), 64'd1);
      check("bp_tdata", a_resp_tdata, 64'h0123456789ABCDEF);
      check("bp_tuser", 64'(a_resp_tuser), 64'h122);
      check("bp_cmd_tready", 64'(a_cmd_tready), 64'd0);
      check("bp_busy", 64'(a_busy), 64'd1);
      check("bp_no_set_stb", 64'(a_set_stb), 64'd0);
      tick();
    end
    check("bp_still_held", 64'(a_resp_tvalid), 64'd1);
    resp_tready = 1'b1;
    tick();
    check("bp_release_tvalid", 64'(a_resp_tvalid), 64'd0);
    check("bp_release_busy", 64'(a_busy), 64'd0);
    check("bp_release_idle_t", 64'(t_cmd_tready), 64'd1);
    check("bp_release_idle_s", 64'(s_cmd_tready), 64'd1);

    // Timeout, then a late strobe that only the long-window instances use
    send(8'h33, 8'h44, 32'h0, 1'b1);
    tick();
    tick();
    tick();
    check("to2_not_early", 64'(t_resp_tvalid), 64'd0);
    check("to2_busy", 64'(t_busy), 64'd1);
    tick();
    check("to2_tvalid_5th", 64'(t_resp_tvalid), 64'd1);
    check("to2_tdata", t_resp_tdata, 64'd0);
    check("to2_tuser", 64'(t_resp_tuser), 64'h333);
    tick();
    check("to2_idle", 64'(t_cmd_tready), 64'd1);
    rb_stb  = 1'b1;
    rb_data = 64'hFEDCBA9876543210;
    tick();
    rb_stb  = 1'b0;
    rb_data = '0;
    check("late_stb_no_resp", 64'(t_resp_tvalid), 64'd0);
    check("late_stb_tdata", t_resp_tdata, 64'd0);
    check("long_rd_tdata", a_resp_tdata, 64'hFEDCBA9876543210);
    check("long_rd_tuser", 64'(a_resp_tuser), 64'h133);
    tick();

    // Strobe on the final window cycle beats the timeout
    send(8'h44, 8'h55, 32'h0, 1'b1);
    tick();
    tick();
    tick();
    rb_stb  = 1'b1;
    rb_data = 64'hA5A500001234_5678;
    tick();
    rb_stb  = 1'b0;
    rb_data = '0;
    check("tie_tvalid", 64'(t_resp_tvalid), 64'd1);
    check("tie_tdata", t_resp_tdata, 64'hA5A5000012345678);
    check("tie_tuser", 64'(t_resp_tuser), 64'h144);
    tick();

    // Normal write after the timeouts
    send(8'h55, 8'h3C, 32'h12345678, 1'b0);
    check("wr2_set_stb", 64'(t_set_stb), 64'd1);
    check("wr2_set_addr", 64'(t_set_addr), 64'h3C);
    check("wr2_set_data", 64'(t_set_data), 64'h12345678);
    tick();
    check("wr2_tvalid", 64'(t_resp_tvalid), 64'd1);
    check("wr2_tuser", 64'(t_resp_tuser), 64'h055);
    tick();

    // Reset during RB_WAIT
    send(8'h66, 8'h77, 32'h0, 1'b1);
    tick();
    check("pre_rst_rb_addr", 64'(a_rb_addr), 64'h77);
    #3;
    reset = 1'b1;
    #1;
    check("arst_set_stb", 64'(a_set_stb), 64'd0);
    check("arst_set_addr", 64'(a_set_addr), 64'd0);
    check("arst_set_data", 64'(a_set_data), 64'd0);
    check("arst_rb_addr", 64'(a_rb_addr), 64'd0);
    check("arst_resp_tvalid", 64'(a_resp_tvalid), 64'd0);
    check("arst_resp_tdata", a_resp_tdata, 64'd0);
    check("arst_resp_tuser", 64'(a_resp_tuser), 64'd0);
    check("arst_busy", 64'(a_busy), 64'd0);
    check("arst_cmd_tready", 64'(a_cmd_tready), 64'd0);
    check("arst_busy_t", 64'(t_busy), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rel_cmd_tready_a", 64'(a_cmd_tready), 64'd1);
    check("rel_cmd_tready_t", 64'(t_cmd_tready), 64'd1);
    check("rel_cmd_tready_s", 64'(s_cmd_tready), 64'd1);
    for (int i = 0; i < 80; i++) begin
      rb_stb  = (i % 7 == 3);
      rb_data = 64'hCAFE;
      tick();
      check("aborted_no_output",
            64'({a_resp_tvalid, t_resp_tvalid, s_resp_tvalid, a_set_stb, t_set_stb, s_set_stb, a_busy}),
            64'd0);
    end
    rb_stb = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
